// File: rtl/mv_avalon_loader_if.sv
// mv_avalon_loader_if: Avalon-MM read bus between the loader and the memory fabric.
interface mv_avalon_loader_if #(
  parameter int N = 8,
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] address;
  logic read;
  logic waitrequest;
  logic [N*DATA_WIDTH-1:0] readdata;
  logic readdatavalid;
  modport master(output address, read, input waitrequest, readdata, readdatavalid);
  modport slave(input address, read, output waitrequest, readdata, readdatavalid);
endinterface

// File: rtl/mv_avalon_loader.sv
// mv_avalon_loader: Avalon-MM read master filling the A/B FIFOs of the matrix-vector unit.
// Define LOADER_PREFETCH_EN to overlap the next word's read with the current word's pushes.
module mv_avalon_loader #(
  parameter int N = 8,
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 32
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  mv_avalon_loader_if.master avm,
  output logic [N-1:0] a_wren_out,
  output logic [N*DATA_WIDTH-1:0] a_data_out,
  output logic b_wren_out,
  output logic [DATA_WIDTH-1:0] b_data_out,
  input  logic [N-1:0] a_full,
  input  logic b_full,
  output logic busy,
  output logic load_done
);
  localparam int KW = $clog2(N + 1);
  localparam int JW = $clog2(N);
  localparam int WORD_BYTES = N * DATA_WIDTH / 8;
  typedef enum logic [2:0] {IDLE, REQ, WAIT_DATA, PUSH, DONE} state_t;
  state_t state_q;
  logic [KW-1:0] k_q;
  logic [JW-1:0] j_q;
  logic [ADDR_WIDTH-1:0] base_q, addr_q;
  logic [N*DATA_WIDTH-1:0] word_q;
  logic read_q, busy_q, done_q;
  logic last_row, tgt_full, push_en;
  logic [DATA_WIDTH-1:0] cur_byte;
`ifdef LOADER_PREFETCH_EN
  logic [N*DATA_WIDTH-1:0] hold_q;
  logic hold_v_q, pend_q, next_rdy;
`endif
  function automatic logic [ADDR_WIDTH-1:0] word_addr(input int k);
    return base_q + ADDR_WIDTH'(k) * ADDR_WIDTH'(WORD_BYTES);
  endfunction
  assign avm.address = addr_q;
  assign avm.read = read_q;
  assign busy = busy_q;
  assign load_done = done_q;
  // Row N is the B word; rows below N go to the A FIFO of the same index.
  always_comb begin
    last_row = k_q == KW'(N);
    tgt_full = last_row ? b_full : a_full[k_q[JW-1:0]];
    push_en = state_q == PUSH && !tgt_full;
    cur_byte = word_q[j_q*DATA_WIDTH +: DATA_WIDTH];
    a_wren_out = push_en && !last_row ? N'(1) << k_q[JW-1:0] : '0;
    a_data_out = push_en && !last_row ? (N*DATA_WIDTH)'(cur_byte) << (k_q[JW-1:0]*DATA_WIDTH) : '0;
    b_wren_out = push_en && last_row;
    b_data_out = b_wren_out ? cur_byte : '0;
  end
`ifdef LOADER_PREFETCH_EN
  assign next_rdy = hold_v_q || (pend_q && avm.readdatavalid);
`endif
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      k_q <= '0;
      j_q <= '0;
      base_q <= '0;
      addr_q <= '0;
      word_q <= '0;
      read_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
`ifdef LOADER_PREFETCH_EN
      hold_q <= '0;
      hold_v_q <= 1'b0;
      pend_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE, DONE: if (start) begin
          base_q <= base_addr;
          addr_q <= base_addr;
          read_q <= 1'b1;
          k_q <= '0;
          j_q <= '0;
          busy_q <= 1'b1;
          done_q <= 1'b0;
          state_q <= REQ;
        end
        REQ: if (!avm.waitrequest) begin
          read_q <= 1'b0;
          state_q <= WAIT_DATA;
        end
        WAIT_DATA: if (avm.readdatavalid) begin
          word_q <= avm.readdata;
          state_q <= PUSH;
`ifdef LOADER_PREFETCH_EN
          if (!last_row) begin
            read_q <= 1'b1;
            addr_q <= word_addr(int'(k_q) + 1);
          end
`endif
        end
        PUSH: begin
`ifdef LOADER_PREFETCH_EN
          if (read_q && !avm.waitrequest) begin
            read_q <= 1'b0;
            pend_q <= 1'b1;
          end
          if (pend_q && avm.readdatavalid) begin
            hold_q <= avm.readdata;
            hold_v_q <= 1'b1;
            pend_q <= 1'b0;
          end
`endif
          if (!tgt_full) begin
            j_q <= j_q + 1'b1;
            if (j_q == JW'(N - 1)) begin
              if (last_row) begin
                busy_q <= 1'b0;
                done_q <= 1'b1;
                state_q <= DONE;
              end else begin
                k_q <= k_q + 1'b1;
`ifdef LOADER_PREFETCH_EN
                // Data may land in the same cycle as the last byte, so bypass the holding register.
                if (next_rdy) begin
                  word_q <= hold_v_q ? hold_q : avm.readdata;
                  hold_v_q <= 1'b0;
                  pend_q <= 1'b0;
                  if (int'(k_q) + 1 < N) begin
                    read_q <= 1'b1;
                    addr_q <= word_addr(int'(k_q) + 2);
                  end
                end else if (read_q && avm.waitrequest) begin
                  state_q <= REQ;
                end else begin
                  pend_q <= 1'b0;
                  state_q <= WAIT_DATA;
                end
`else
                read_q <= 1'b1;
                addr_q <= word_addr(int'(k_q) + 1);
                state_q <= REQ;
`endif
              end
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mv_avalon_loader.sv
// tb_mv_avalon_loader: scoreboard bench; expected reads and FIFO writes come from a word/byte list model.
module tb_mv_avalon_loader;
  localparam int N = 8, DW = 8, AW = 32;
`ifdef LOADER_PREFETCH_EN
  localparam int T_LOAD = 75, T_WAIT = 0;
`else
  localparam int T_LOAD = 91, T_WAIT = 5;
`endif
  logic clk = 0, rst_n = 0, start = 0, b_full = 0;
  logic [AW-1:0] base_addr = '0;
  logic [N-1:0] a_full = '0, a_wren_out;
  logic [N*DW-1:0] a_data_out;
  logic b_wren_out, busy, load_done;
  logic [DW-1:0] b_data_out;
  mv_avalon_loader_if #(.N(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) avm();
  mv_avalon_loader #(.N(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .avm(avm),
    .a_wren_out(a_wren_out), .a_data_out(a_data_out), .b_wren_out(b_wren_out),
    .b_data_out(b_data_out), .a_full(a_full), .b_full(b_full), .busy(busy), .load_done(load_done)
  );
  always #5 clk = ~clk;

  typedef struct packed {
    logic [N-1:0] aw;
    logic [N*DW-1:0] ad;
    logic bw;
    logic [DW-1:0] bd;
  } wr_t;
  typedef struct {
    int due;
    logic [63:0] d;
  } resp_t;
  wr_t wr_q[$];
  logic [AW-1:0] addr_q[$];
  resp_t resp_q[$];
  resp_t r_tmp;
  logic [63:0] mem [logic [31:0]];
  int n_cmp = 0, n_err = 0;
  int rnd_mode = 0, lat_max = 1, ec = 0;
  int stall_left = 0, full_left = 0, row2_writes = 0;
  bit stall_cmp = 0, full_script = 0, acc = 0;
  logic [AW-1:0] stall_addr = '0, acc_addr = '0;
  logic [115:0] all_out;
  assign all_out = {avm.read, avm.address, a_wren_out, a_data_out, b_wren_out, b_data_out, busy, load_done};

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] mem_rd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : 64'h0;
  endfunction

  task automatic fill(input logic [AW-1:0] base, input int kind);
    for (int k = 0; k <= N; k++)
      mem[base + 8 * k] = kind == 0 ? {8{8'(k + 1)}} : {$urandom, $urandom};
    if (kind == 2) mem[base + 8 * N] = 64'h0706050403020100;
  endtask

  // Word k feeds FIFO k (B for k == N), bytes in ascending order.
  task automatic model_load(input logic [AW-1:0] base);
    wr_t e;
    logic [63:0] w;
    for (int k = 0; k <= N; k++) begin
      addr_q.push_back(base + 8 * k);
      w = mem_rd(base + 8 * k);
      for (int j = 0; j < N; j++) begin
        e.aw = k < N ? N'(1) << k : '0;
        e.ad = k < N ? (N * DW)'(w[8 * j +: 8]) << (DW * k) : '0;
        e.bw = k == N;
        e.bd = k == N ? w[8 * j +: 8] : '0;
        wr_q.push_back(e);
      end
    end
  endtask

  // Memory responder and stall drivers, updated just after each rising edge.
  always @(posedge clk) begin
    #1;
    ec++;
    if (!rst_n) begin
      resp_q.delete();
      avm.readdatavalid = 0;
      avm.waitrequest = 0;
    end else begin
      if (acc) begin
        r_tmp.due = ec + int'($urandom_range(lat_max, 1)) - 1;
        r_tmp.d = mem_rd(acc_addr);
        resp_q.push_back(r_tmp);
      end
      if (resp_q.size() > 0 && resp_q[0].due <= ec) begin
        avm.readdatavalid = 1;
        avm.readdata = resp_q[0].d;
        void'(resp_q.pop_front());
      end else begin
        avm.readdatavalid = rnd_mode != 0 && resp_q.size() == 0 && $urandom_range(3, 0) == 0;
        avm.readdata = {$urandom, $urandom};
      end
      if (stall_left > 0 && avm.read && avm.address == stall_addr) begin
        avm.waitrequest = 1;
        stall_left--;
      end else avm.waitrequest = rnd_mode != 0 && $urandom_range(2, 0) == 0;
      if (full_script && row2_writes == 3 && full_left > 0) begin
        a_full = 8'b0000_0100;
        full_left--;
      end else if (rnd_mode != 0) begin
        a_full = N'($urandom) & N'($urandom);
        b_full = $urandom_range(3, 0) == 0;
      end else begin
        a_full = '0;
        b_full = 0;
      end
    end
  end

  // Monitor: pops the scoreboard whenever the DUT issues a read or a FIFO write.
  always @(negedge clk) begin
    acc = rst_n && avm.read && !avm.waitrequest;
    acc_addr = avm.address;
    if (rst_n) begin
      if (acc) begin
        chk("read_expected", addr_q.size() > 0, 1);
        if (addr_q.size() > 0) chk("read_addr", avm.address, addr_q.pop_front());
      end
      if (stall_cmp && avm.waitrequest) chk("stall_hold", {avm.read, avm.address}, {1'b1, stall_addr});
      if (|a_wren_out || b_wren_out) begin
        chk("wr_full_respected", {a_wren_out & a_full, b_wren_out & b_full}, 0);
        if (a_wren_out[2]) row2_writes++;
        chk("wr_expected", wr_q.size() > 0, 1);
        if (wr_q.size() > 0) chk("fifo_write", {a_wren_out, a_data_out, b_wren_out, b_data_out}, wr_q.pop_front());
      end
    end
  end

  task automatic run_load(input logic [AW-1:0] base, input int exp);
    int n;
    model_load(base);
    @(posedge clk);
    #1 start = 1;
    base_addr = base;
    @(posedge clk);
    #1 start = 0;
    base_addr = $urandom;
    n = 1;
    @(negedge clk);
    chk("start_accepted", {busy, load_done}, 2'b10);
    while (!load_done && n < 3000) begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    chk("load_completed", load_done, 1);
    if (exp > 0) chk("load_cycles", n, exp);
    chk("queues_drained", addr_q.size() + wr_q.size(), 0);
    chk("idle_busy", busy, 0);
  endtask

  initial begin
    logic [AW-1:0] b;
    avm.waitrequest = 0;
    avm.readdatavalid = 0;
    avm.readdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", all_out, 0);
    @(posedge clk);
    #1 rst_n = 1;
    fill(32'h1000, 0);
    run_load(32'h1000, T_LOAD);
    stall_addr = 32'h1018;
    stall_left = 5;
    stall_cmp = 1;
    run_load(32'h1000, T_LOAD + T_WAIT);
    stall_cmp = 0;
    chk("stall_consumed", stall_left, 0);
    full_script = 1;
    full_left = 4;
    row2_writes = 0;
    run_load(32'h1000, T_LOAD + 4);
    full_script = 0;
    chk("row2_write_count", row2_writes, 8);
    chk("full_consumed", full_left, 0);
    fill(32'h2000, 2);
    run_load(32'h2000, T_LOAD);
    fill(32'h3000, 1);
    fill(32'h5000, 1);
    model_load(32'h3000);
    @(posedge clk);
    #1 start = 1;
    base_addr = 32'h3000;
    @(posedge clk);
    #1 start = 0;
    repeat (19) @(posedge clk);
    #1 start = 1;
    base_addr = 32'h5000;
    @(posedge clk);
    #1 start = 0;
    @(negedge clk);
    chk("busy_start_ignored", {busy, load_done}, 2'b10);
    repeat (19) @(posedge clk);
    #1 rst_n = 0;
    #1 chk("reset_mid_load", all_out, 0);
    addr_q.delete();
    wr_q.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    run_load(32'h3000, T_LOAD);
    rnd_mode = 1;
    lat_max = 3;
    for (int t = 0; t < 4; t++) begin
      b = $urandom & 32'h7FFF_FFF8;
      fill(b, 1);
      run_load(b, 0);
    end
    rnd_mode = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
